// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues a req/ready read for the current pc, latches the
// returned word into ir, and reports a misaligned pc or a memory timeout.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [5:0]  op,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [4:0]  rd_idx,
    output logic [15:0] immd16,
    output logic [25:0] immd26,
    output logic        busy,
    output logic        done,
    output logic [1:0]  fault_code
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FAULT_OK        = 2'b00,
        FAULT_MISALIGN  = 2'b01,
        FAULT_TIMEOUT   = 2'b10
    } fault_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q;
    fault_e      fault_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] ir_q;
    logic        done_q;
    logic [7:0]  cnt_q;

    // NOTE: all state updates here use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            fault_q    <= FAULT_OK;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            ir_q       <= RESET_INSTR;
            done_q     <= 1'b0;
            cnt_q      <= 8'h0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (pc[1:0] == 2'b00) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc;
                            cnt_q      <= 8'h0;
                            fault_q    <= FAULT_OK;
                            state_q    <= WAIT;
                        end else begin
                            fault_q <= FAULT_MISALIGN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Ready takes priority over an expiring wait budget.
                    if (mem_ready) begin
                        ir_q      <= mem_rdata;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h1;
                        if (cnt_q == CNT_LAST) begin
                            mem_req_q <= 1'b0;
                            fault_q   <= FAULT_TIMEOUT;
                            done_q    <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign ir         = ir_q;
    assign done       = done_q;
    assign fault_code = fault_q;
    assign busy       = (state_q == WAIT);

    assign op     = ir_q[31:26];
    assign rs_idx = ir_q[25:21];
    assign rt_idx = ir_q[20:16];
    assign rd_idx = ir_q[15:11];
    assign immd16 = ir_q[15:0];
    assign immd26 = ir_q[25:0];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the multi-cycle CPU, directly downstream of the program counter.
- Takes the current pc when the control FSM pulses start, runs a req/ready read handshake with instruction memory, and latches the returned word into the instruction register.
- Exposes decoded fields: immd16 and immd26 feed next-pc computation; op and register indices feed the decoder and register file.
- Detects misaligned pc and memory timeout.

Parameters:
TIMEOUT, 16, maximum WAIT cycles without mem_ready before a timeout fault (legal range 2..255).
RESET_INSTR, 32'h0000_0000, value of ir after reset.

Ports:
clk  input  1  clock, rising edge.
nRST  input  1  reset, asynchronous, active-low.
start  input  1  fetch request from control FSM; single-cycle pulse.
pc  input  32  address to fetch; sampled on the edge that accepts start.
mem_req  output  1  registered read request to instruction memory.
mem_addr  output  32  registered read address.
mem_ready  input  1  memory has valid mem_rdata this cycle.
mem_rdata  input  32  instruction word from memory.
ir  output  32  instruction register.
op  output  6  ir[31:26].
rs_idx  output  5  ir[25:21].
rt_idx  output  5  ir[20:16].
rd_idx  output  5  ir[15:11].
immd16  output  16  ir[15:0].
immd26  output  26  ir[25:0].
busy  output  1  high while state is WAIT.
done  output  1  one-cycle pulse: fetch finished (success or fault).
fault_code  output  2  00 ok, 01 misaligned pc, 10 timeout; valid from done until next accepted start.

Behaviour:
- Reset (asynchronous, any state, including mid-WAIT):
  - state=IDLE, mem_req=0, mem_addr=0, ir=RESET_INSTR.
  - done=0, fault_code=00, wait counter=0.
  - An aborted request is never completed.
- States: IDLE, WAIT.
- IDLE, start=1, pc[1:0]==00:
  - mem_req<=1, mem_addr<=pc, counter<=0, fault_code<=00; next state WAIT.
- IDLE, start=1, pc[1:0]!=00:
  - No memory request issued; ir unchanged.
  - fault_code<=01, done<=1 for one cycle; stay IDLE.
- WAIT, mem_ready=1 at an edge:
  - ir<=mem_rdata, mem_req<=0, done<=1 for one cycle, fault_code stays 00; next state IDLE.
- WAIT, mem_ready=0:
  - counter<=counter+1 (8-bit, saturating).
  - mem_req and mem_addr held stable; mem_addr is never changed while mem_req=1.
- WAIT, mem_ready=0 and counter==TIMEOUT-1:
  - mem_req<=0, fault_code<=10, done<=1; ir unchanged; next state IDLE.
- mem_ready and the timeout condition in the same cycle: ready wins and the fetch succeeds.
- start while busy: ignored, not queued.
- mem_ready while IDLE: ignored.
- start on the same edge done is high: accepted normally (back-to-back fetches).
- Latency: start accepted at edge E0 puts mem_req high after E0. With mem_ready high in that cycle, ir is updated and done is high after E1. Each memory wait state adds one cycle. Worst-case timeout: done after edge E0+TIMEOUT.
- done is a registered one-cycle pulse and is cleared the following cycle.
- busy = (state==WAIT), combinational from state.
- Decoded fields are combinational slices of ir. They change only when ir loads, so immd16/immd26 are stable for the whole execute phase.
- ir is written only on a successful fetch.

Test Plan:
- Reset with nRST=0, then release: ir=32'h0, mem_req=0, done=0, busy=0, fault_code=00.
- pc=32'h0000_0040 with start pulse; memory returns ready 1 cycle later with rdata=32'h2108_0004:
  - Before the fetch completes: mem_addr=0x40.
  - On completion: ir=0x21080004, op=6'h08, rs_idx=8, rt_idx=8, immd16=16'h0004, done pulses exactly once.
  - Repeat with 3 wait states: done arrives 3 cycles later and mem_addr stays stable throughout.
- pc=32'h0000_0042 with start: no mem_req, done pulse with fault_code=01, ir keeps its prior value.
- start with mem_ready never asserted, TIMEOUT=16: mem_req drops and done pulses with fault_code=10 after 16 cycles.
  - Repeat with ready arriving on the final cycle: the fetch succeeds with fault_code=00.
- Assert start mid-WAIT: ignored, mem_addr unchanged. Then pull nRST low mid-WAIT: mem_req drops immediately, state returns to IDLE, no done pulse after release.
